chroma_lock_controller: RTL and testbench

Line-rate sequencer for the NTSC chroma subcarrier loop and colour killer. It gates per-sample burst phase-error and burst-amplitude samples from the colour decoder during each burst window and reduces them to one error value per line. It then runs a PI update that drives the NCO phase-increment offset, and decides lock and colour-kill state with hysteresis. It sits beside the colour decoder and feeds the decoder's loop offset and saturation gain inputs.

---
 rtl/chroma_pkg.sv | 56 +++++
 rtl/hyst_counter.sv | 34 +++
 rtl/chroma_lock_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_chroma_lock_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chroma_pkg.sv
// Shared definitions for the chroma subcarrier lock controller.
// Holds the sequencer state type, shared widths, the nominal NCO increment
// and the saturation/clamp helpers used by the per-line PI update.
package chroma_pkg;

   localparam int unsigned ERR_W  = 12;  // demodulator sample width
   localparam int unsigned OFF_W  = 32;  // NCO offset width
   localparam int unsigned SUM_W  = 24;  // burst-window accumulator width
   localparam int unsigned CNT_W  = 12;  // gated sample counter width
   localparam int unsigned WD_W   = 13;  // line watchdog width
   localparam int unsigned WIDE_W = 40;  // headroom for the PI arithmetic

   // fsc / 74.25 MHz * 2^32, the free-running NCO increment
   localparam logic [OFF_W-1:0] NCO_NOMINAL_INC = 32'd207057652;
   localparam logic signed [OFF_W-1:0] OFFSET_LIMIT_DEFAULT = 32'sd4194304;

   typedef enum logic [2:0] {
      StIdle,
      StWaitBurst,
      StAccum,
      StUpdate,
      StApply
   } lock_state_t;

   // Saturate a widened accumulator value to 16-bit signed.
   function automatic logic signed [15:0] sat16(input logic signed [SUM_W:0] v);
      logic signed [SUM_W:0] hi;
      logic signed [SUM_W:0] lo;
      hi = (SUM_W+1)'(32767);
      lo = -(SUM_W+1)'(32768);
      if (v > hi) begin
         return 16'sd32767;
      end else if (v < lo) begin
         return -16'sd32768;
      end else begin
         return v[15:0];
      end
   endfunction

   // Symmetric clamp of a wide intermediate to +/-lim.
   function automatic logic signed [OFF_W-1:0] clamp_off(input logic signed [WIDE_W-1:0] v,
                                                         input logic signed [OFF_W-1:0]  lim);
      logic signed [WIDE_W-1:0] hi;
      logic signed [WIDE_W-1:0] lo;
      hi = {{(WIDE_W-OFF_W){lim[OFF_W-1]}}, lim};
      lo = -hi;
      if (v > hi) begin
         return hi[OFF_W-1:0];
      end else if (v < lo) begin
         return lo[OFF_W-1:0];
      end else begin
         return v[OFF_W-1:0];
      end
   endfunction

endpackage

// File: rtl/hyst_counter.sv
// Consecutive-line counter used for lock, weak-burst and strong-burst runs.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   inc      : count one qualifying line (saturates at MAX)
//   clr      : clear the run; wins over inc
//   hit      : this inc brings the run to MAX (combinational)
module hyst_counter #(
   parameter int unsigned MAX = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic hit
);

   localparam int unsigned CW = $clog2(MAX + 1);

   logic [CW-1:0] count;

   // Independent of clr so the caller may fold hit into clr without a loop.
   assign hit = inc && (count >= CW'(MAX - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count < CW'(MAX))) begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/chroma_lock_controller.sv
// Line-rate sequencer for the NTSC chroma subcarrier loop and colour killer.
// Accumulates burst phase error and amplitude over each burst window, runs a
// PI update on the per-line error to steer the NCO, and tracks lock and
// colour-kill state with hysteresis. A watchdog resets the loop when bursts
// stop arriving.
// Ports:
//   clk, rst      : pixel clock, asynchronous active-high reset
//   burst_gate    : burst window aligned to the demodulator pipeline
//   phase_err     : per-sample V-axis error (positive = NCO leads)
//   burst_amp     : per-sample U-axis amplitude
//   sat_gain_in   : user saturation setting
//   phase_offset  : offset added to the nominal NCO increment
//   sat_gain_out  : sat_gain_in, or 0 while colour is killed
//   locked        : loop lock indicator
//   color_kill    : colour-killer state
//   line_valid    : one-cycle strobe when a line update is applied
module chroma_lock_controller
   import chroma_pkg::*;
#(
   parameter int unsigned             ACC_SHIFT    = 6,
   parameter int unsigned             MIN_SAMPLES  = 16,
   parameter int unsigned             KP_SHIFT     = 8,
   parameter int unsigned             KI_SHIFT     = 2,
   parameter logic signed [OFF_W-1:0] OFFSET_LIMIT = OFFSET_LIMIT_DEFAULT,
   parameter int unsigned             LOCK_TOL     = 16,
   parameter int unsigned             LOCK_LINES   = 8,
   parameter int unsigned             KILL_LO      = 64,
   parameter int unsigned             KILL_HI      = 128,
   parameter int unsigned             KILL_LINES   = 4,
   parameter int unsigned             LINE_TIMEOUT = 6000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    burst_gate,
   input  logic signed [ERR_W-1:0] phase_err,
   input  logic signed [ERR_W-1:0] burst_amp,
   input  logic signed [12:0]      sat_gain_in,
   output logic signed [OFF_W-1:0] phase_offset,
   output logic signed [12:0]      sat_gain_out,
   output logic                    locked,
   output logic                    color_kill,
   output logic                    line_valid
);

   lock_state_t              state;
   logic signed [SUM_W-1:0]  err_sum;
   logic [SUM_W-1:0]         amp_sum;
   logic [CNT_W-1:0]         cnt;
   logic [WD_W-1:0]          wd_cnt;
   logic signed [OFF_W-1:0]  integ;

   // Sample-rate datapath
   logic [ERR_W-1:0]         amp_abs;
   logic signed [SUM_W-1:0]  err_first;
   logic signed [SUM_W-1:0]  err_next;
   logic [SUM_W:0]           amp_add;
   logic [SUM_W-1:0]         amp_next;
   logic [CNT_W-1:0]         cnt_next;

   // Line-rate datapath
   logic signed [15:0]       e_line;
   logic signed [15:0]       a_line;
   logic [15:0]              a_u;
   logic signed [16:0]       e_ext;
   logic [16:0]              e_abs;
   logic signed [WIDE_W-1:0] e_wide;
   logic signed [WIDE_W-1:0] integ_wide;
   logic signed [OFF_W-1:0]  integ_new;
   logic signed [WIDE_W-1:0] integ_new_wide;
   logic signed [OFF_W-1:0]  off_new;
   logic                     e_in_tol;
   logic                     e_far;
   logic                     a_weak;
   logic                     a_strong;

   logic wd_fire;
   logic upd;
   logic lock_hit;
   logic weak_hit;
   logic strong_hit;

   // |-2048| = 2048 still fits 12 bits unsigned
   assign amp_abs   = burst_amp[ERR_W-1] ? $unsigned(-burst_amp) : $unsigned(burst_amp);
   assign err_first = {{(SUM_W-ERR_W){phase_err[ERR_W-1]}}, phase_err};
   assign err_next  = err_sum + err_first;
   assign amp_add   = {1'b0, amp_sum} + {{(SUM_W+1-ERR_W){1'b0}}, amp_abs};
   assign amp_next  = amp_add[SUM_W] ? '1 : amp_add[SUM_W-1:0];
   assign cnt_next  = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   always_comb begin
      e_line         = sat16($signed({err_sum[SUM_W-1], err_sum}) >>> ACC_SHIFT);
      a_line         = sat16($signed({1'b0, amp_sum >> ACC_SHIFT}));
      a_u            = $unsigned(a_line);
      e_ext          = {e_line[15], e_line};
      e_abs          = e_ext[16] ? $unsigned(-e_ext) : $unsigned(e_ext);
      e_wide         = {{(WIDE_W-16){e_line[15]}}, e_line};
      integ_wide     = {{(WIDE_W-OFF_W){integ[OFF_W-1]}}, integ};
      // Negative feedback: a leading NCO (positive error) gets a smaller increment
      integ_new      = clamp_off(integ_wide - (e_wide <<< KI_SHIFT), OFFSET_LIMIT);
      integ_new_wide = {{(WIDE_W-OFF_W){integ_new[OFF_W-1]}}, integ_new};
      off_new        = clamp_off(integ_new_wide - (e_wide <<< KP_SHIFT), OFFSET_LIMIT);
      e_in_tol       = e_abs < 17'(LOCK_TOL);
      e_far          = e_abs >= 17'(4 * LOCK_TOL);
      a_weak         = a_u < 16'(KILL_LO);
      a_strong       = a_u > 16'(KILL_HI);
   end

   assign wd_fire = (state != StIdle) && (wd_cnt == WD_W'(LINE_TIMEOUT));
   assign upd     = (state == StUpdate) && !wd_fire;

   hyst_counter #(
      .MAX (LOCK_LINES)
   ) u_lock_cnt (
      .clk (clk),
      .rst (rst),
      .inc (upd && e_in_tol),
      .clr ((upd && !e_in_tol) || wd_fire),
      .hit (lock_hit)
   );

   // Kill counters clear themselves on the line that flips the kill state.
   hyst_counter #(
      .MAX (KILL_LINES)
   ) u_weak_cnt (
      .clk (clk),
      .rst (rst),
      .inc (upd && !color_kill && a_weak),
      .clr ((upd && !color_kill && !a_weak) || weak_hit),
      .hit (weak_hit)
   );

   hyst_counter #(
      .MAX (KILL_LINES)
   ) u_strong_cnt (
      .clk (clk),
      .rst (rst),
      .inc (upd && color_kill && a_strong),
      .clr ((upd && color_kill && !a_strong) || strong_hit),
      .hit (strong_hit)
   );

   // Outputs are registered at the end of the UPDATE cycle so that they, and
   // the line_valid strobe, are visible during APPLY (two cycles after the
   // gate falls).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= StIdle;
         err_sum      <= '0;
         amp_sum      <= '0;
         cnt          <= '0;
         wd_cnt       <= '0;
         integ        <= '0;
         phase_offset <= '0;
         locked       <= 1'b0;
         color_kill   <= 1'b1;
         line_valid   <= 1'b0;
      end else begin
         line_valid <= 1'b0;
         if ((state == StIdle) || (state == StApply)) begin
            wd_cnt <= '0;
         end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end

         if (wd_fire) begin
            state        <= StWaitBurst;
            err_sum      <= '0;
            amp_sum      <= '0;
            cnt          <= '0;
            wd_cnt       <= '0;
            integ        <= '0;
            phase_offset <= '0;
            locked       <= 1'b0;
            color_kill   <= 1'b1;
         end else begin
            unique case (state)
               StIdle: begin
                  // Never start mid-burst
                  if (!burst_gate) begin
                     state <= StWaitBurst;
                  end
               end
               StWaitBurst: begin
                  if (burst_gate) begin
                     err_sum <= err_first;
                     amp_sum <= {{(SUM_W-ERR_W){1'b0}}, amp_abs};
                     cnt     <= CNT_W'(1);
                     state   <= StAccum;
                  end else begin
                     err_sum <= '0;
                     amp_sum <= '0;
                     cnt     <= '0;
                  end
               end
               StAccum: begin
                  if (burst_gate) begin
                     err_sum <= err_next;
                     amp_sum <= amp_next;
                     cnt     <= cnt_next;
                  end else if (cnt >= CNT_W'(MIN_SAMPLES)) begin
                     state <= StUpdate;
                  end else begin
                     state <= StWaitBurst;
                  end
               end
               StUpdate: begin
                  integ        <= integ_new;
                  phase_offset <= off_new;
                  line_valid   <= 1'b1;
                  if (lock_hit) begin
                     locked <= 1'b1;
                  end else if (e_far) begin
                     locked <= 1'b0;
                  end
                  if (weak_hit) begin
                     color_kill <= 1'b1;
                  end else if (strong_hit) begin
                     color_kill <= 1'b0;
                  end
                  state <= StApply;
               end
               StApply: begin
                  state <= StWaitBurst;
               end
               default: begin
                  state <= StIdle;
               end
            endcase
         end
      end
   end

   assign sat_gain_out = color_kill ? '0 : sat_gain_in;

endmodule

// File: tb/tb_chroma_lock_controller.sv
module tb_chroma_lock_controller;

   localparam longint LIMIT = 4194304;
   localparam int     SAT_IN = 1234;

   logic               clk;
   logic               rst;
   logic               burst_gate;
   logic signed [11:0] phase_err;
   logic signed [11:0] burst_amp;
   logic signed [12:0] sat_gain_in;
   logic signed [31:0] phase_offset;
   logic signed [12:0] sat_gain_out;
   logic               locked;
   logic               color_kill;
   logic               line_valid;

   int errors = 0;
   int checks = 0;

   // Reference state: one entry per valid line, plain integer arithmetic
   longint m_integ = 0;
   longint m_off = 0;
   int     m_lock_run = 0;
   bit     m_locked = 0;
   bit     m_kill = 1;
   int     m_weak = 0;
   int     m_strong = 0;

   chroma_lock_controller dut (
      .clk          (clk),
      .rst          (rst),
      .burst_gate   (burst_gate),
      .phase_err    (phase_err),
      .burst_amp    (burst_amp),
      .sat_gain_in  (sat_gain_in),
      .phase_offset (phase_offset),
      .sat_gain_out (sat_gain_out),
      .locked       (locked),
      .color_kill   (color_kill),
      .line_valid   (line_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint clampl(input longint v);
      if (v > LIMIT) return LIMIT;
      if (v < -LIMIT) return -LIMIT;
      return v;
   endfunction

   function automatic longint sat16l(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // One valid line: average, PI step, lock and kill hysteresis.
   task automatic model_line(input longint esum, input longint asum);
      longint e;
      longint a;
      longint ae;
      e = sat16l(esum >>> 6);
      a = sat16l(asum / 64);
      m_integ = clampl(m_integ - e * 4);
      m_off   = clampl(m_integ - e * 256);
      ae = (e < 0) ? -e : e;
      if (ae < 16) begin
         if (m_lock_run < 8) m_lock_run++;
         if (m_lock_run == 8) m_locked = 1;
      end else begin
         m_lock_run = 0;
         if (ae >= 64) m_locked = 0;
      end
      if (!m_kill) begin
         if (a < 64) begin
            m_weak++;
            if (m_weak == 4) begin
               m_kill = 1;
               m_weak = 0;
            end
         end else begin
            m_weak = 0;
         end
      end else begin
         if (a > 128) begin
            m_strong++;
            if (m_strong == 4) begin
               m_kill = 0;
               m_strong = 0;
            end
         end else begin
            m_strong = 0;
         end
      end
   endtask

   task automatic model_watchdog();
      m_integ = 0;
      m_off = 0;
      m_locked = 0;
      m_lock_run = 0;
      m_kill = 1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".phase_offset"}, phase_offset, m_off);
      check({tag, ".locked"}, locked, m_locked);
      check({tag, ".color_kill"}, color_kill, m_kill);
      check({tag, ".sat_gain_out"}, sat_gain_out, m_kill ? 0 : SAT_IN);
   endtask

   // Drive one burst of n samples with random jitter, then check the strobe
   // timing and the line result against the model.
   task automatic run_line(input int n, input int eb, input int ej, input int ab, input int aj);
      longint esum;
      longint asum;
      int pe;
      int pa;
      esum = 0;
      asum = 0;
      for (int i = 0; i < n; i++) begin
         pe = eb + ((ej > 0) ? int'($urandom_range(0, 2 * ej)) - ej : 0);
         if (pe > 2047) pe = 2047;
         if (pe < -2048) pe = -2048;
         pa = ab + ((aj > 0) ? int'($urandom_range(0, 2 * aj)) - aj : 0);
         if (pa < 0) pa = 0;
         if (pa > 2047) pa = 2047;
         if ($urandom_range(0, 1) == 1) pa = -pa;
         burst_gate = 1'b1;
         phase_err  = pe[11:0];
         burst_amp  = pa[11:0];
         esum += pe;
         asum += (pa < 0) ? -pa : pa;
         @(negedge clk);
      end
      burst_gate = 1'b0;
      phase_err  = '0;
      burst_amp  = '0;
      @(negedge clk);
      check("line_valid_early", line_valid, 0);
      @(negedge clk);
      if (n >= 16) model_line(esum, asum);
      check("line_valid", line_valid, (n >= 16) ? 1 : 0);
      check_model("line");
      @(negedge clk);
      check("line_valid_single", line_valid, 0);
      @(negedge clk);
   endtask

   typedef struct {
      int     n;
      int     err;
      int     amp;
      longint off;
      bit     lck;
      bit     kill;
   } vec_t;

   vec_t vecs[21];

   initial begin
      vecs[0]  = '{100,  640, 200, -260000, 0, 1};
      vecs[1]  = '{100,  640, 200, -264000, 0, 1};
      vecs[2]  = '{100,  640, 200, -268000, 0, 1};
      vecs[3]  = '{100,  640, 200, -272000, 0, 0};
      vecs[4]  = '{100,  320, 200, -146000, 0, 0};
      for (int i = 5; i <= 11; i++) vecs[i] = '{100, 0, 200, -18000, 0, 0};
      vecs[12] = '{100,    0, 200,  -18000, 1, 0};
      vecs[13] = '{100,   64, 200,  -44000, 0, 0};
      vecs[14] = '{100,    0,  25,  -18400, 0, 0};
      vecs[15] = '{100,    0,  25,  -18400, 0, 0};
      vecs[16] = '{100,    0,  25,  -18400, 0, 0};
      vecs[17] = '{100,    0,  25,  -18400, 0, 1};
      vecs[18] = '{100,    0,  60,  -18400, 0, 1};
      vecs[19] = '{100, -640,  60,  241600, 0, 1};
      vecs[20] = '{100,   -1,  60,  -13880, 0, 1};

      rst         = 1'b1;
      burst_gate  = 1'b0;
      phase_err   = '0;
      burst_amp   = '0;
      sat_gain_in = 13'(SAT_IN);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset in the middle of a burst
      burst_gate = 1'b1;
      phase_err  = 12'sd640;
      burst_amp  = 12'sd200;
      repeat (50) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.phase_offset", phase_offset, 0);
      check("rst.locked", locked, 0);
      check("rst.color_kill", color_kill, 1);
      check("rst.line_valid", line_valid, 0);
      check("rst.sat_gain_out", sat_gain_out, 0);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      burst_gate = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("rst.no_partial_line", line_valid, 0);
         @(negedge clk);
      end
      check("rst.offset_held", phase_offset, 0);

      // Directed table: constant error, lock, unlock, colour killer, rounding
      for (int i = 0; i < 21; i++) begin
         run_line(vecs[i].n, vecs[i].err, 0, vecs[i].amp, 0);
         check($sformatf("vec%0d.phase_offset", i), phase_offset, vecs[i].off);
         check($sformatf("vec%0d.locked", i), locked, vecs[i].lck);
         check($sformatf("vec%0d.color_kill", i), color_kill, vecs[i].kill);
      end

      // Short burst leaves everything alone
      run_line(10, 500, 0, 200, 0);
      check("short.phase_offset", phase_offset, -13880);

      // Randomised lines against the model
      for (int k = 0; k < 40; k++) begin
         int eb;
         int ab;
         int sel;
         sel = int'($urandom_range(0, 3));
         case (sel)
            0:       eb = 0;
            1:       eb = int'($urandom_range(0, 40)) - 20;
            2:       eb = int'($urandom_range(0, 200)) - 100;
            default: eb = int'($urandom_range(0, 1600)) - 800;
         endcase
         case ($urandom_range(0, 2))
            0:       ab = 20;
            1:       ab = 100;
            default: ab = 220;
         endcase
         run_line(int'($urandom_range(8, 120)), eb, 8, ab, 15);
      end

      // Sustained maximum error: e saturates, offset and integrator clamp
      for (int k = 0; k < 34; k++) run_line(1100, 2047, 0, 200, 0);
      check("clamp.neg_offset", phase_offset, -LIMIT);
      run_line(100, 0, 0, 200, 0);
      check("clamp.integ_neg", phase_offset, -LIMIT);
      run_line(1100, -2048, 0, 200, 0);
      check("clamp.pos_offset", phase_offset, LIMIT);
      for (int k = 0; k < 8; k++) run_line(100, 0, 0, 200, 0);
      check("pre_wd.locked", locked, 1);
      check("pre_wd.color_kill", color_kill, 0);

      // Bursts stop: watchdog resets the loop
      burst_gate = 1'b0;
      repeat (6100) @(negedge clk);
      model_watchdog();
      check("wd.phase_offset", phase_offset, 0);
      check("wd.locked", locked, 0);
      check("wd.color_kill", color_kill, 1);
      check("wd.sat_gain_out", sat_gain_out, 0);
      run_line(100, 640, 0, 200, 0);
      check("post_wd.phase_offset", phase_offset, -260000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
